// File: rtl/led_pkg.sv
// Purpose: shared definitions for the status-light sequencer: FSM state
//          encodings, light pin patterns, dwell-register select codes and
//          small helpers mapping states to colours.
// Ports:   none (package).
package led_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BLUE  = 3'd1,
    ST_GREEN = 3'd2,
    ST_RED   = 3'd3,
    ST_OVR   = 3'd4
  } state_t;

  localparam logic [2:0] LED_OFF   = 3'b000;
  localparam logic [2:0] LED_RED   = 3'b001;
  localparam logic [2:0] LED_BLUE  = 3'b010;
  localparam logic [2:0] LED_GREEN = 3'b100;

  localparam logic [1:0] SEL_BLUE  = 2'd0;
  localparam logic [1:0] SEL_GREEN = 2'd1;
  localparam logic [1:0] SEL_RED   = 2'd2;
  localparam logic [1:0] SEL_NONE  = 2'd3;

  function automatic logic [2:0] state_color(state_t s);
    logic [2:0] c;
    c = LED_OFF;
    case (s)
      ST_BLUE:  c = LED_BLUE;
      ST_GREEN: c = LED_GREEN;
      ST_RED:   c = LED_RED;
      default:  c = LED_OFF;
    endcase
    return c;
  endfunction

  function automatic state_t next_color(state_t s);
    state_t n;
    n = ST_BLUE;
    case (s)
      ST_BLUE:  n = ST_GREEN;
      ST_GREEN: n = ST_RED;
      default:  n = ST_BLUE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/led_seq_ctrl_if.sv
// Purpose: bus bundle between the sequencer and its neighbours: the dwell
//          configuration write port and the override req/ack handshake.
// Signals: cfg_we/cfg_sel/cfg_data - dwell register write strobe, select, value
//          ovr_req/ovr_color        - override request (level) and colour
//          ovr_ack                  - override granted, driven by the sequencer
// Modports: master = config/override agent, slave = led_seq_ctrl.
interface led_seq_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             cfg_we;
  logic [1:0]       cfg_sel;
  logic [CNT_W-1:0] cfg_data;
  logic             ovr_req;
  logic [2:0]       ovr_color;
  logic             ovr_ack;

  modport master (
    output cfg_we, cfg_sel, cfg_data, ovr_req, ovr_color,
    input  ovr_ack
  );

  modport slave (
    input  cfg_we, cfg_sel, cfg_data, ovr_req, ovr_color,
    output ovr_ack
  );
endinterface

// File: rtl/led_seq_ctrl_dwell_counter.sv
// Purpose: dwell down-counter for the sequencer. Load has priority; otherwise
//          it decrements while en is high and stops at zero.
// Ports:   clk, rst_n        - clock, async active-low reset (count -> 0)
//          load, load_val    - synchronous load of a new count
//          en                - decrement enable
//          cnt, zero         - current count and terminal-count flag
module dwell_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && !zero) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/led_seq_ctrl.sv
// Purpose: programmable BLUE->GREEN->RED sequencer for the status light with
//          per-colour dwell registers, pause and a req/ack colour override.
// Ports:   clk, rst_n  - clock, async active-low reset
//          en          - 1 = run the sequence, 0 = freeze colour and count
//          bus         - config write port and override handshake (slave)
//          light       - registered light pins (red=001, blue=010, green=100)
//          state_o     - current FSM state for debug
//          step_pulse  - one-cycle pulse in the first cycle after a colour advance
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | after reset, light off, waiting for en (or an override)
// ST_BLUE  | blue shown, dwell counter running while en
// ST_GREEN | green shown, dwell counter running while en
// ST_RED   | red shown, dwell counter running while en
// ST_OVR   | override granted, light follows ovr_color, saved state kept
module led_seq_ctrl
  import led_pkg::*;
#(
  parameter int          CNT_W       = 16,
  parameter logic [15:0] DWELL_BLUE  = 16'd4,
  parameter logic [15:0] DWELL_GREEN = 16'd4,
  parameter logic [15:0] DWELL_RED   = 16'd4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  led_seq_ctrl_if.slave        bus,
  output logic [2:0]           light,
  output logic [2:0]           state_o,
  output logic                 step_pulse
);

  state_t           state_q, state_d;
  state_t           saved_q, saved_d;
  logic [2:0]       light_q, light_d;
  logic             ack_q, ack_d;
  logic             step_q, step_d;
  logic [CNT_W-1:0] dwell_blue_q, dwell_green_q, dwell_red_q;
  logic [CNT_W-1:0] dwell_sel, load_val;
  logic             cnt_load, cnt_en, cnt_zero;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_blue_q  <= CNT_W'(DWELL_BLUE);
      dwell_green_q <= CNT_W'(DWELL_GREEN);
      dwell_red_q   <= CNT_W'(DWELL_RED);
    end else if (bus.cfg_we) begin
      case (bus.cfg_sel)
        SEL_BLUE:  dwell_blue_q  <= bus.cfg_data;
        SEL_GREEN: dwell_green_q <= bus.cfg_data;
        SEL_RED:   dwell_red_q   <= bus.cfg_data;
        default:   ;
      endcase
    end
  end

  // Reload value for the colour being entered; a dwell of 0 behaves as 1.
  always_comb begin
    dwell_sel = dwell_blue_q;
    case (state_d)
      ST_GREEN: dwell_sel = dwell_green_q;
      ST_RED:   dwell_sel = dwell_red_q;
      default:  dwell_sel = dwell_blue_q;
    endcase
    load_val = (dwell_sel == '0) ? '0 : dwell_sel - CNT_W'(1);
  end

  dwell_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (load_val),
    .en       (cnt_en),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      saved_q <= ST_BLUE;
      light_q <= LED_OFF;
      ack_q   <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      light_q <= light_d;
      ack_q   <= ack_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    saved_d  = saved_q;
    light_d  = light_q;
    ack_d    = ack_q;
    step_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      ST_IDLE, ST_BLUE, ST_GREEN, ST_RED: begin
        ack_d = 1'b0;
        // Override outranks both en and a dwell expiring in the same cycle.
        if (bus.ovr_req) begin
          state_d = ST_OVR;
          saved_d = state_q;
          light_d = bus.ovr_color;
          ack_d   = 1'b1;
        end else if (en) begin
          if (state_q == ST_IDLE) begin
            state_d  = ST_BLUE;
            light_d  = LED_BLUE;
            cnt_load = 1'b1;
          end else if (cnt_zero) begin
            state_d  = next_color(state_q);
            light_d  = state_color(next_color(state_q));
            cnt_load = 1'b1;
            step_d   = 1'b1;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      ST_OVR: begin
        if (bus.ovr_req) begin
          light_d = bus.ovr_color;
          ack_d   = 1'b1;
        end else begin
          // Returning colour always restarts with its full dwell.
          state_d  = saved_q;
          light_d  = state_color(saved_q);
          ack_d    = 1'b0;
          cnt_load = (saved_q != ST_IDLE);
        end
      end
      default: begin
        state_d = ST_IDLE;
        light_d = LED_OFF;
        ack_d   = 1'b0;
      end
    endcase
  end

  assign light       = light_q;
  assign state_o     = state_q;
  assign step_pulse  = step_q;
  assign bus.ovr_ack = ack_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
module tb_led_seq_ctrl;
  import led_pkg::*;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_OVR  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en;
  logic [2:0] light;
  logic [2:0] state_o;
  logic       step_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  led_seq_ctrl_if #(.CNT_W(16)) bus ();

  led_seq_ctrl #(
    .CNT_W(16), .DWELL_BLUE(16'd4), .DWELL_GREEN(16'd4), .DWELL_RED(16'd4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .bus        (bus),
    .light      (light),
    .state_o    (state_o),
    .step_pulse (step_pulse)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase index + cycles left in the current colour.
  int         m_mode;
  int         m_idx;
  int         m_left;
  int         m_ret_idle;
  int         m_dw[3];
  logic [2:0] m_ovr_col;
  logic       m_step;
  logic [2:0] col_tab[3];

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_idx = 0; m_left = 0; m_ret_idle = 0;
    m_dw[0] = 4; m_dw[1] = 4; m_dw[2] = 4;
    m_ovr_col = 3'b000; m_step = 1'b0;
  endtask

  task automatic model_step();
    m_step = 1'b0;
    if (m_mode == M_IDLE) begin
      if (bus.ovr_req) begin
        m_mode = M_OVR; m_ret_idle = 1; m_ovr_col = bus.ovr_color;
      end else if (en) begin
        m_mode = M_RUN; m_idx = 0; m_left = eff(m_dw[0]);
      end
    end else if (m_mode == M_RUN) begin
      if (bus.ovr_req) begin
        m_mode = M_OVR; m_ret_idle = 0; m_ovr_col = bus.ovr_color;
      end else if (en) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_idx = (m_idx + 1) % 3;
          m_left = eff(m_dw[m_idx]);
          m_step = 1'b1;
        end
      end
    end else begin
      if (bus.ovr_req) m_ovr_col = bus.ovr_color;
      else if (m_ret_idle != 0) m_mode = M_IDLE;
      else begin
        m_mode = M_RUN; m_left = eff(m_dw[m_idx]);
      end
    end
    if (bus.cfg_we && bus.cfg_sel != 2'd3) m_dw[bus.cfg_sel] = int'(bus.cfg_data);
  endtask

  function automatic logic [2:0] exp_light();
    if (m_mode == M_IDLE) return LED_OFF;
    if (m_mode == M_RUN) return col_tab[m_idx];
    return m_ovr_col;
  endfunction

  function automatic logic [2:0] exp_state();
    if (m_mode == M_IDLE) return 3'(ST_IDLE);
    if (m_mode == M_OVR) return 3'(ST_OVR);
    if (m_idx == 0) return 3'(ST_BLUE);
    if (m_idx == 1) return 3'(ST_GREEN);
    return 3'(ST_RED);
  endfunction

  initial begin
    col_tab[0] = LED_BLUE; col_tab[1] = LED_GREEN; col_tab[2] = LED_RED;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("cmp_light", 16'(light), 16'(exp_light()));
      chk("cmp_state", 16'(state_o), 16'(exp_state()));
      chk("cmp_ack", 16'(bus.ovr_ack), 16'(m_mode == M_OVR));
      chk("cmp_step", 16'(step_pulse), 16'(m_step));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [15:0] val);
    bus.cfg_we = 1'b1; bus.cfg_sel = sel; bus.cfg_data = val;
    tick(1);
    bus.cfg_we = 1'b0;
  endtask

  initial begin
    en = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_sel = 2'd0; bus.cfg_data = 16'd0;
    bus.ovr_req = 1'b0; bus.ovr_color = 3'b000;
    #1 rst_n = 1'b0;
    tick(2);
    chk("rst_light", 16'(light), 16'(LED_OFF));
    chk("rst_ack", 16'(bus.ovr_ack), 16'd0);
    chk("rst_state", 16'(state_o), 16'(ST_IDLE));
    chk("rst_step", 16'(step_pulse), 16'd0);

    // 1: basic 4/4/4 rotation
    rst_n = 1'b1; en = 1'b1;
    tick(1); chk("t1_blue_first", 16'(light), 16'(LED_BLUE));
    chk("t1_no_step_from_idle", 16'(step_pulse), 16'd0);
    tick(3); chk("t1_blue_last", 16'(light), 16'(LED_BLUE));
    tick(1); chk("t1_green", 16'(light), 16'(LED_GREEN));
    chk("t1_step_g", 16'(step_pulse), 16'd1);
    tick(4); chk("t1_red", 16'(light), 16'(LED_RED));
    tick(4); chk("t1_blue_again", 16'(light), 16'(LED_BLUE));
    chk("t1_step_b", 16'(step_pulse), 16'd1);

    // 2: dwell writes apply at the next load only; dwell 0 lasts one cycle
    cfg_write(SEL_GREEN, 16'd2);
    tick(2); chk("t2_blue_unchanged", 16'(light), 16'(LED_BLUE));
    tick(1); chk("t2_green", 16'(light), 16'(LED_GREEN));
    tick(1); chk("t2_green_2nd", 16'(light), 16'(LED_GREEN));
    tick(1); chk("t2_red_after_2", 16'(light), 16'(LED_RED));
    cfg_write(SEL_BLUE, 16'd0);
    tick(2); chk("t2_red_last", 16'(light), 16'(LED_RED));
    tick(1); chk("t2_blue_1cyc", 16'(light), 16'(LED_BLUE));
    tick(1); chk("t2_green_next", 16'(light), 16'(LED_GREEN));
    chk("t2_step", 16'(step_pulse), 16'd1);
    cfg_write(SEL_GREEN, 16'd4);
    cfg_write(SEL_BLUE, 16'd4);
    chk("t2_red_reached", 16'(light), 16'(LED_RED));
    tick(3); tick(1); chk("t2_blue4", 16'(light), 16'(LED_BLUE));

    // 3: pause two cycles into GREEN
    tick(4); tick(1);
    chk("t3_green_c2", 16'(light), 16'(LED_GREEN));
    en = 1'b0;
    tick(5); chk("t3_hold", 16'(light), 16'(LED_GREEN));
    chk("t3_hold_step", 16'(step_pulse), 16'd0);
    en = 1'b1;
    tick(2); chk("t3_green_c4", 16'(light), 16'(LED_GREEN));
    tick(1); chk("t3_red", 16'(light), 16'(LED_RED));

    // 4: override at RED's final count
    tick(3);
    bus.ovr_req = 1'b1; bus.ovr_color = 3'b111;
    tick(1);
    chk("t4_ack", 16'(bus.ovr_ack), 16'd1);
    chk("t4_light", 16'(light), 16'h7);
    chk("t4_no_step", 16'(step_pulse), 16'd0);
    bus.ovr_color = 3'b101;
    tick(1); chk("t4_color_track", 16'(light), 16'h5);
    tick(1);
    bus.ovr_req = 1'b0;
    tick(1);
    chk("t4_red_back", 16'(light), 16'(LED_RED));
    chk("t4_ack_low", 16'(bus.ovr_ack), 16'd0);
    tick(3); chk("t4_red_full", 16'(light), 16'(LED_RED));
    tick(1); chk("t4_blue", 16'(light), 16'(LED_BLUE));

    // 5: override from IDLE
    rst_n = 1'b0; en = 1'b0;
    tick(1); rst_n = 1'b1;
    tick(1);
    bus.ovr_req = 1'b1; bus.ovr_color = 3'b011;
    tick(1); chk("t5_ovr_light", 16'(light), 16'h3);
    chk("t5_ovr_state", 16'(state_o), 16'(ST_OVR));
    tick(1);
    bus.ovr_req = 1'b0;
    tick(1); chk("t5_idle_light", 16'(light), 16'(LED_OFF));
    chk("t5_idle_state", 16'(state_o), 16'(ST_IDLE));
    tick(2); chk("t5_stay_idle", 16'(state_o), 16'(ST_IDLE));

    // 6: async reset mid-override
    en = 1'b1;
    tick(1);
    bus.ovr_req = 1'b1; bus.ovr_color = 3'b110;
    tick(2);
    chk("t6_in_ovr", 16'(bus.ovr_ack), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_light", 16'(light), 16'(LED_OFF));
    chk("t6_rst_ack", 16'(bus.ovr_ack), 16'd0);
    chk("t6_rst_state", 16'(state_o), 16'(ST_IDLE));
    @(negedge clk);
    bus.ovr_req = 1'b0; en = 1'b0;
    rst_n = 1'b1;
    cfg_write(SEL_NONE, 16'd1);
    chk("t6_idle_after", 16'(state_o), 16'(ST_IDLE));
    en = 1'b1;
    tick(1); chk("t6_blue", 16'(light), 16'(LED_BLUE));
    tick(3); chk("t6_sel3_ignored", 16'(light), 16'(LED_BLUE));
    tick(1); chk("t6_green", 16'(light), 16'(LED_GREEN));
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
